wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2.sv | 181 ++++++++++++++++++
 tb/tb_wb_arbiter2.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter2.sv
// Two-master Wishbone arbiter (round robin) with slave no-ack timeout and bus-error abort.
// Grant one cycle after cyc is seen in IDLE; data/ack paths combinational; a granted master holds the bus until it drops cyc.
module wb_arbiter2 #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,

  input  logic [31:0] m0_adr_i,
  input  logic [31:0] m0_dat_i,
  output logic [31:0] m0_dat_o,
  input  logic [3:0]  m0_sel_i,
  input  logic        m0_we_i,
  input  logic        m0_cyc_i,
  input  logic        m0_stb_i,
  output logic        m0_ack_o,
  output logic        m0_err_o,

  input  logic [31:0] m1_adr_i,
  input  logic [31:0] m1_dat_i,
  output logic [31:0] m1_dat_o,
  input  logic [3:0]  m1_sel_i,
  input  logic        m1_we_i,
  input  logic        m1_cyc_i,
  input  logic        m1_stb_i,
  output logic        m1_ack_o,
  output logic        m1_err_o,

  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic        s_stb_o,
  input  logic [31:0] s_dat_i,
  input  logic        s_ack_i,

  output logic [1:0]  grant_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2,
    ABORT  = 2'd3
  } state_t;

  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  state_t      state_nxt;
  logic        last_m1;
  logic [7:0]  to_cnt;
  logic        stb_wait;
  logic        to_hit;
  logic        m0_err_q;
  logic        m1_err_q;
  logic        timeout_q;

  // A strobe is outstanding when the granted master strobes and the slave has not answered.
  assign stb_wait = s_stb_o & ~s_ack_i;
  assign to_hit   = stb_wait & (to_cnt == TO_LAST);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (m0_cyc_i && m1_cyc_i) begin
          state_nxt = last_m1 ? GRANT0 : GRANT1;
        end else if (m0_cyc_i) begin
          state_nxt = GRANT0;
        end else if (m1_cyc_i) begin
          state_nxt = GRANT1;
        end
      end
      GRANT0: begin
        if (!m0_cyc_i) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          state_nxt = ABORT;
        end
      end
      GRANT1: begin
        if (!m1_cyc_i) begin
          state_nxt = IDLE;
        end else if (to_hit) begin
          state_nxt = ABORT;
        end
      end
      ABORT:   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    grant_o = 2'b00;
    s_adr_o = m0_adr_i;
    s_dat_o = m0_dat_i;
    s_sel_o = m0_sel_i;
    s_we_o  = m0_we_i;
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    case (state)
      GRANT0: begin
        grant_o = 2'b01;
        s_cyc_o = m0_cyc_i;
        s_stb_o = m0_stb_i;
      end
      GRANT1: begin
        grant_o = 2'b10;
        s_adr_o = m1_adr_i;
        s_dat_o = m1_dat_i;
        s_sel_o = m1_sel_i;
        s_we_o  = m1_we_i;
        s_cyc_o = m1_cyc_i;
        s_stb_o = m1_stb_i;
      end
      default: begin
        grant_o = 2'b00;
      end
    endcase
  end

  assign m0_dat_o  = s_dat_i;
  assign m1_dat_o  = s_dat_i;
  assign m0_ack_o  = grant_o[0] & s_ack_i;
  assign m1_ack_o  = grant_o[1] & s_ack_i;
  assign m0_err_o  = m0_err_q;
  assign m1_err_o  = m1_err_q;
  assign timeout_o = timeout_q;

  // Round-robin memory: reset to m1 so m0 wins the first contention.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      last_m1 <= 1'b1;
    end else if (state == IDLE && state_nxt == GRANT0) begin
      last_m1 <= 1'b0;
    end else if (state == IDLE && state_nxt == GRANT1) begin
      last_m1 <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      to_cnt <= 8'd0;
    end else if (state_nxt != state || (state != GRANT0 && state != GRANT1) || s_ack_i) begin
      to_cnt <= 8'd0;
    end else if (stb_wait) begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Error and timeout flags are registered so they line up with the one-cycle ABORT state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      m0_err_q  <= 1'b0;
      m1_err_q  <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      m0_err_q  <= (state == GRANT0) && (state_nxt == ABORT);
      m1_err_q  <= (state == GRANT1) && (state_nxt == ABORT);
      timeout_q <= (state_nxt == ABORT);
    end
  end

  a_grant_onehot: assert property (@(posedge clk) disable iff (!rst) grant_o != 2'b11);
  a_abort_no_grant: assert property (@(posedge clk) disable iff (!rst) timeout_o |-> (grant_o == 2'b00 && !s_cyc_o));

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed vector bench for wb_arbiter2 built with TIMEOUT=8.
module tb_wb_arbiter2;

  logic        clk;
  logic        rst;
  logic [31:0] m0_adr_i, m0_dat_i, m0_dat_o;
  logic [3:0]  m0_sel_i;
  logic        m0_we_i, m0_cyc_i, m0_stb_i, m0_ack_o, m0_err_o;
  logic [31:0] m1_adr_i, m1_dat_i, m1_dat_o;
  logic [3:0]  m1_sel_i;
  logic        m1_we_i, m1_cyc_i, m1_stb_i, m1_ack_o, m1_err_o;
  logic [31:0] s_adr_o, s_dat_o, s_dat_i;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o, s_stb_o, s_ack_i;
  logic [1:0]  grant_o;
  logic        timeout_o;

  int n_vec  = 0;
  int n_miss = 0;

  wb_arbiter2 #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst),
    .m0_adr_i(m0_adr_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o), .m0_sel_i(m0_sel_i),
    .m0_we_i(m0_we_i), .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o),
    .m1_adr_i(m1_adr_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o), .m1_sel_i(m1_sel_i),
    .m1_we_i(m1_we_i), .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_dat_i(s_dat_i), .s_ack_i(s_ack_i),
    .grant_o(grant_o), .timeout_o(timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // in_v = {m0_cyc, m0_stb, m1_cyc, m1_stb, s_ack}
  // exp_v = {grant[1:0], s_cyc, s_stb, m0_ack, m1_ack, m0_err, m1_err, timeout}
  typedef struct {
    logic [4:0] in_v;
    logic [8:0] exp_v;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic [4:0] v);
    {m0_cyc_i, m0_stb_i, m1_cyc_i, m1_stb_i, s_ack_i} = v;
  endtask

  function automatic logic [8:0] obs();
    return {grant_o, s_cyc_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, timeout_o};
  endfunction

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    m0_adr_i = 32'h0000_1000; m0_dat_i = 32'hAAAA_0000; m0_sel_i = 4'h3; m0_we_i = 1'b0;
    m1_adr_i = 32'h2000_0004; m1_dat_i = 32'h5555_1111; m1_sel_i = 4'hC; m1_we_i = 1'b1;
    s_dat_i = 32'hDEAD_BEEF;
    drive(5'b00000);
    #3;
    chk("reset_outputs", {23'd0, obs()}, 32'd0);
    @(posedge clk);
    #2;
    rst = 1'b1;

    // Contention, round robin and ack gating
    tbl.push_back('{5'b00000, 9'b00_00_00_000});
    tbl.push_back('{5'b11110, 9'b00_00_00_000});
    tbl.push_back('{5'b11110, 9'b01_11_00_000});
    tbl.push_back('{5'b11111, 9'b01_11_10_000});
    tbl.push_back('{5'b00110, 9'b01_00_00_000});
    tbl.push_back('{5'b00110, 9'b00_00_00_000});
    tbl.push_back('{5'b00111, 9'b10_11_01_000});
    tbl.push_back('{5'b00000, 9'b10_00_00_000});
    tbl.push_back('{5'b00000, 9'b00_00_00_000});
    tbl.push_back('{5'b11110, 9'b00_00_00_000});
    tbl.push_back('{5'b11111, 9'b01_11_10_000});
    tbl.push_back('{5'b00110, 9'b01_00_00_000});
    tbl.push_back('{5'b11110, 9'b00_00_00_000});
    tbl.push_back('{5'b11111, 9'b10_11_01_000});
    tbl.push_back('{5'b11000, 9'b10_00_00_000});
    tbl.push_back('{5'b11110, 9'b00_00_00_000});
    tbl.push_back('{5'b11111, 9'b01_11_10_000});
    tbl.push_back('{5'b00110, 9'b01_00_00_000});
    tbl.push_back('{5'b11110, 9'b00_00_00_000});
    tbl.push_back('{5'b11111, 9'b10_11_01_000});
    tbl.push_back('{5'b11000, 9'b10_00_00_000});
    tbl.push_back('{5'b00000, 9'b00_00_00_000});
    tbl.push_back('{5'b00001, 9'b00_00_00_000});
    tbl.push_back('{5'b00000, 9'b00_00_00_000});

    foreach (tbl[i]) begin
      drive(tbl[i].in_v);
      mid();
      chk($sformatf("vec%0d", i), {23'd0, obs()}, {23'd0, tbl[i].exp_v});
      next_cyc();
    end

    // Slave-side mux: m0 fields while idle, m1 fields while m1 owns the bus
    drive(5'b00110);
    mid();
    chk("idle_adr_m0", s_adr_o, 32'h0000_1000);
    chk("idle_cyc_stb", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
    next_cyc();
    mid();
    chk("g1_grant", {30'd0, grant_o}, 32'd2);
    chk("g1_adr", s_adr_o, 32'h2000_0004);
    chk("g1_dat", s_dat_o, 32'h5555_1111);
    chk("g1_sel_we", {27'd0, s_sel_o, s_we_o}, {27'd0, 4'hC, 1'b1});
    chk("m0_rdata", m0_dat_o, 32'hDEAD_BEEF);
    chk("m1_rdata", m1_dat_o, 32'hDEAD_BEEF);
    next_cyc();
    drive(5'b00111);
    mid();
    chk("g1_ack", {30'd0, m0_ack_o, m1_ack_o}, 32'd1);
    next_cyc();
    drive(5'b00000);
    mid();
    next_cyc();

    // m1 timeout: 8 unacked strobes, then a one-cycle abort, then re-arbitration
    drive(5'b00110);
    mid();
    chk("to1_idle", {30'd0, grant_o}, 32'd0);
    next_cyc();
    for (int i = 1; i <= 8; i++) begin
      mid();
      chk($sformatf("to1_wait%0d", i), {23'd0, obs()}, {23'd0, 9'b10_11_00_000});
      next_cyc();
    end
    drive(5'b00111);
    mid();
    chk("to1_abort", {23'd0, obs()}, {23'd0, 9'b00_00_00_011});
    next_cyc();
    drive(5'b00110);
    mid();
    chk("to1_after", {23'd0, obs()}, 32'd0);
    next_cyc();
    mid();
    chk("to1_regrant", {23'd0, obs()}, {23'd0, 9'b10_11_00_000});
    next_cyc();
    drive(5'b00111);
    mid();
    next_cyc();
    drive(5'b00000);
    mid();
    next_cyc();

    // Ack on the last budget cycle is a normal completion
    drive(5'b11000);
    mid();
    next_cyc();
    for (int i = 1; i <= 7; i++) begin
      mid();
      chk($sformatf("lastack_wait%0d", i), {23'd0, obs()}, {23'd0, 9'b01_11_00_000});
      next_cyc();
    end
    drive(5'b11001);
    mid();
    chk("lastack_ack", {23'd0, obs()}, {23'd0, 9'b01_11_10_000});
    next_cyc();
    drive(5'b00000);
    mid();
    chk("lastack_noabort", {23'd0, obs()}, {23'd0, 9'b01_00_00_000});
    next_cyc();
    mid();
    chk("lastack_idle", {23'd0, obs()}, 32'd0);
    next_cyc();

    // m0 gives up after 3 unacked cycles; the next transfer gets the full budget
    drive(5'b11000);
    mid();
    next_cyc();
    for (int i = 1; i <= 3; i++) begin
      mid();
      next_cyc();
    end
    drive(5'b00000);
    mid();
    chk("drop_no_err", {23'd0, obs()}, {23'd0, 9'b01_00_00_000});
    next_cyc();
    mid();
    chk("drop_idle", {23'd0, obs()}, 32'd0);
    next_cyc();
    drive(5'b11000);
    mid();
    next_cyc();
    for (int i = 1; i <= 8; i++) begin
      mid();
      chk($sformatf("budget_wait%0d", i), {23'd0, obs()}, {23'd0, 9'b01_11_00_000});
      next_cyc();
    end
    mid();
    chk("budget_abort", {23'd0, obs()}, {23'd0, 9'b00_00_00_101});
    next_cyc();
    drive(5'b00000);
    mid();
    next_cyc();

    // Asynchronous reset in the middle of a pending m1 strobe
    drive(5'b00110);
    mid();
    next_cyc();
    mid();
    chk("rst1_pre", {30'd0, grant_o}, 32'd2);
    #2;
    rst = 1'b0;
    #1;
    chk("rst1_async", {23'd0, obs()}, 32'd0);
    next_cyc();
    drive(5'b11110);
    #2;
    rst = 1'b1;
    mid();
    chk("rst1_release_idle", {23'd0, obs()}, 32'd0);
    next_cyc();
    mid();
    chk("rst1_m0_wins", {23'd0, obs()}, {23'd0, 9'b01_11_00_000});
    next_cyc();
    drive(5'b00000);
    mid();
    next_cyc();

    // Reset while m0 owns the bus must restore the round-robin pointer
    drive(5'b11000);
    mid();
    next_cyc();
    mid();
    chk("rst2_pre", {30'd0, grant_o}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("rst2_async", {23'd0, obs()}, 32'd0);
    next_cyc();
    drive(5'b11110);
    #2;
    rst = 1'b1;
    mid();
    next_cyc();
    mid();
    chk("rst2_m0_wins", {30'd0, grant_o}, 32'd1);
    next_cyc();
    drive(5'b00000);
    mid();
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
